// File: rtl/sprite_regs.sv
// sprite_regs: double-buffered sprite position/enable register file.
//
// The CPU writes a shadow copy of each sprite's X, Y and CTRL. Writing the
// COMMIT/STATUS register (address 0x3) arms a pending flag. On the next frame
// pulse that sees the flag set, all shadow values are copied into the active
// set in one edge. This means the display never shows a half-updated sprite
// table.
//
// Ports
//   clk          pixel clock, all logic on the rising edge
//   rst          synchronous, active-high reset
//   frame        one-cycle start-of-frame pulse
//   cpu_we       write strobe, one transfer per cycle
//   cpu_re       read strobe
//   cpu_addr     {sprite index[3:2], slot[1:0]}
//   cpu_wdata    write data
//   cpu_rdata    registered read data, held until the next read
//   cpu_rvalid   one-cycle strobe, cpu_rdata valid
//   spr_x/spr_y  active coordinates, sprite i at [i*CORDW +: CORDW], signed
//   spr_en       active enable per sprite
//   commit_pulse one cycle high when the active set was just updated
//
// Read handshake: there is no ready/backpressure. Every cycle with cpu_re=1
// is accepted. Exactly one cycle later cpu_rvalid is high for one cycle, and
// cpu_rdata carries the shadow value sampled before any same-cycle write.
// cpu_rdata keeps that value until the next accepted read.
//
// Register map per sprite index i:
//   slot 0 X, slot 1 Y, slot 2 CTRL (bit0 = enable),
//   slot 3 COMMIT/STATUS for index 0, otherwise reads 0 and ignores writes.
//   STATUS reads back {pending, frame_cnt[CORDW-2:0]}.
// Indices >= NSPR read 0 and ignore writes.

module sprite_regs #(
    parameter int CORDW = 16,
    parameter int NSPR  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame,
    input  logic                    cpu_we,
    input  logic                    cpu_re,
    input  logic [3:0]              cpu_addr,
    input  logic [CORDW-1:0]        cpu_wdata,
    output logic [CORDW-1:0]        cpu_rdata,
    output logic                    cpu_rvalid,
    output logic [NSPR*CORDW-1:0]   spr_x,
    output logic [NSPR*CORDW-1:0]   spr_y,
    output logic [NSPR-1:0]         spr_en,
    output logic                    commit_pulse
);

    localparam int IW = (NSPR > 1) ? $clog2(NSPR) : 1;

    logic [CORDW-1:0] sh_x  [NSPR];
    logic [CORDW-1:0] sh_y  [NSPR];
    logic             sh_en [NSPR];
    logic [CORDW-1:0] act_x [NSPR];
    logic [CORDW-1:0] act_y [NSPR];
    logic             act_en[NSPR];

    logic             pending;
    logic [CORDW-1:0] frame_cnt;
    logic [CORDW-1:0] rd_mux;

    logic [IW-1:0]    idx;
    logic [1:0]       slot;
    logic             idx_ok;
    logic             is_status;
    logic             do_commit;

    // The counter MSB is kept for wrap behaviour but is not visible in STATUS.
    logic             unused_cnt_msb;
    assign unused_cnt_msb = frame_cnt[CORDW-1];

    assign idx       = cpu_addr[2 +: IW];
    assign slot      = cpu_addr[1:0];
    assign idx_ok    = ({1'b0, cpu_addr[3:2]} < 3'(NSPR));
    assign is_status = (cpu_addr == 4'h3);
    assign do_commit = frame && pending;

    // Read mux sees the current (pre-write) shadow state. A read and write to
    // the same address in one cycle therefore return the old value.
    always_comb begin
        rd_mux = '0;
        if (idx_ok) begin
            case (slot)
                2'd0: rd_mux = sh_x[idx];
                2'd1: rd_mux = sh_y[idx];
                2'd2: rd_mux = {{(CORDW-1){1'b0}}, sh_en[idx]};
                2'd3: rd_mux = is_status ? {pending, frame_cnt[CORDW-2:0]} : '0;
            endcase
        end
    end

    // Shadow registers: CPU writes only.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSPR; i++) begin
                sh_x[i]  <= '0;
                sh_y[i]  <= '0;
                sh_en[i] <= 1'b0;
            end
        end else if (cpu_we && idx_ok) begin
            case (slot)
                2'd0: sh_x[idx]  <= cpu_wdata;
                2'd1: sh_y[idx]  <= cpu_wdata;
                2'd2: sh_en[idx] <= cpu_wdata[0];
                2'd3: ;
            endcase
        end
    end

    // Active set: copied from the shadow as it was before this edge. A
    // shadow write in the committing cycle therefore waits for the next commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSPR; i++) begin
                act_x[i]  <= '0;
                act_y[i]  <= '0;
                act_en[i] <= 1'b0;
            end
        end else if (do_commit) begin
            for (int i = 0; i < NSPR; i++) begin
                act_x[i]  <= sh_x[i];
                act_y[i]  <= sh_y[i];
                act_en[i] <= sh_en[i];
            end
        end
    end

    // Pending flag. A commit write wins over the clear from a same-cycle
    // frame, so a write that coincides with a frame commits on the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending      <= 1'b0;
            commit_pulse <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            commit_pulse <= do_commit;
            if (frame) begin
                frame_cnt <= frame_cnt + CORDW'(1);
            end
            if (cpu_we && is_status) begin
                pending <= 1'b1;
            end else if (do_commit) begin
                pending <= 1'b0;
            end
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_re;
            if (cpu_re) begin
                cpu_rdata <= rd_mux;
            end
        end
    end

    for (genvar g = 0; g < NSPR; g++) begin : g_pack
        assign spr_x[g*CORDW +: CORDW] = act_x[g];
        assign spr_y[g*CORDW +: CORDW] = act_y[g];
        assign spr_en[g]               = act_en[g];
    end

endmodule

// File: doc/sprite_regs.md
SPRITE_REGS -- requirements
Module: sprite_regs

Interface
REQ-001 Parameter CORDW, default 16: signed coordinate width; also the CPU data width.
REQ-002 Parameter NSPR, default 4: number of sprites, power of 2, range 1..4.
REQ-003 clk  input  1: single clock (pixel clock domain); all logic rising-edge.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 frame  input  1: one-cycle pulse at start of each frame, from the VGA timing block.
REQ-006 cpu_we  input  1: write strobe, one transfer per cycle.
REQ-007 cpu_re  input  1: read strobe.
REQ-008 cpu_addr  input  4: {sprite index[3:2], slot[1:0]}.
REQ-009 cpu_wdata  input  CORDW: write data.
REQ-010 cpu_rdata  output  CORDW: read data, registered.
REQ-011 cpu_rvalid  output  1: high for one cycle when cpu_rdata is valid.
REQ-012 spr_x  output  NSPR*CORDW: active X per sprite, sprite i at bits [i*CORDW +: CORDW], signed.
REQ-013 spr_y  output  NSPR*CORDW: active Y per sprite, same packing.
REQ-014 spr_en  output  NSPR: active enable per sprite.
REQ-015 commit_pulse  output  1: one-cycle pulse when the active set was updated.

Function
REQ-016 Register map per sprite index i: slot 0 = X, slot 1 = Y, slot 2 = CTRL (bit0 = enable, other bits read 0), slot 3 = see REQ-017.
REQ-017 Address 0x3 is COMMIT/STATUS: any write sets pending; a read returns {pending, frame_cnt[CORDW-2:0]}; slot 3 of any other index reads 0 and ignores writes.
REQ-018 Addresses with index >= NSPR shall read 0 and ignore writes.
REQ-019 Writes shall update only the shadow copy (shadow X/Y/CTRL) at the clock edge of cpu_we; active outputs are unaffected.
REQ-020 Reads shall return shadow values; cpu_rdata/cpu_rvalid appear the cycle after cpu_re (latency 1) and hold rdata until the next read.
REQ-021 If cpu_we and cpu_re hit the same address in one cycle, the read shall return the pre-write value.
REQ-022 On an edge with frame=1 and pending=1: active <= shadow for all sprites atomically, pending <= 0, and commit_pulse = 1 in the following cycle, in which the new values are visible.
REQ-023 frame=1 with pending=0: active unchanged, commit_pulse stays 0.
REQ-024 A commit write in the same cycle as frame shall set pending but not commit this frame; the commit occurs at the next frame.
REQ-025 A shadow write in the same cycle as a committing frame: active takes the pre-write shadow; the new value lands in shadow and needs a new commit.
REQ-026 frame_cnt (CORDW bits, internal) shall increment on every frame pulse and wrap from all-ones to 0.
REQ-027 Coordinates are stored unmodified (no clamping); negative/offscreen values pass through.

Reset
REQ-028 Reset shall clear, in the next cycle: all shadow and active X/Y to 0, spr_en to 0, pending to 0, frame_cnt to 0, cpu_rdata to 0, cpu_rvalid to 0, commit_pulse to 0.
REQ-029 Reset has priority over frame, cpu_we and cpu_re in the same cycle; a pending commit is discarded.

Verification
REQ-030 Write X=0x0100, Y=0xFFC0, CTRL=1 to sprite 1, no commit, 3 frames -> spr_x/spr_y/spr_en remain 0; reading 0x4/0x5/0x6 returns 0x0100/0xFFC0/0x0001 one cycle after cpu_re.
REQ-031 Then write 0x3 and pulse frame -> next cycle sprite 1 X=0x0100, Y=-64, en=1, commit_pulse high exactly 1 cycle; read 0x3 shows pending=0.
REQ-032 Write 0x3 in the same cycle as frame -> no commit that frame; commit_pulse at next frame.
REQ-033 Commit pending, write sprite 0 X=0x0055 in the frame cycle (shadow previously 0x0011) -> active X=0x0011, shadow reads 0x0055.
REQ-034 Write sprite 2 X=5, commit, then assert rst mid-frame with pending set -> all outputs 0, pending 0; read 0x3 returns 0.
REQ-035 Apply 2^CORDW+2 frame pulses -> frame_cnt wraps; read 0x3 returns 0x0002.
